// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID-stage instruction info,
// branch resolution and the freeze request in; stall/flush controls and
// EX operand selects out.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              ext_stall;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_alu_src;
    logic [REG_AW-1:0] id_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              ex_branch_taken;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic              idex_bubble;
    logic [1:0]        c_data1_src;
    logic [1:0]        c_data2_src;
    logic              stalled;

    // Pipeline side: supplies instruction info, consumes controls.
    modport master (
        output ext_stall, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_alu_src, id_dst, id_reg_write, id_mem_read, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble,
               c_data1_src, c_data2_src, stalled
    );

    // Hazard controller side.
    modport slave (
        input  ext_stall, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_alu_src, id_dst, id_reg_write, id_mem_read, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble,
               c_data1_src, c_data2_src, stalled
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use and
// store-data stall detection, taken-branch squash, and registered EX
// forwarding selects (00 regfile, 10 EX/MEM, 01 MEM/WB).
// Optional macro HAZARD_STATS_EN adds stall_cnt/flush_cnt counters.
module hazard_ctrl #(
    parameter int REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    hazard_ctrl_if.slave   hif
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]    stall_cnt,
    output logic [31:0]    flush_cnt
`endif
);
    typedef enum logic {RUN, STALL} state_t;

    state_t            state;
    logic              idex_valid, idex_rw, idex_mr;
    logic [REG_AW-1:0] idex_dst;
    logic              exmem_valid, exmem_rw;
    logic [REG_AW-1:0] exmem_dst;

    logic ex_rs, ex_rt, mem_rs, mem_rt;
    logic lu, sd, hz, bubble;
    logic [1:0] fwd1, fwd2;

    function automatic logic prod(input logic v, input logic rw,
                                  input logic [REG_AW-1:0] dst,
                                  input logic [REG_AW-1:0] r);
        return v & rw & (dst != '0) & (dst == r);
    endfunction

    // Hazard detection and next forwarding selects from the ID instruction.
    always_comb begin
        ex_rs  = prod(idex_valid, idex_rw, idex_dst, hif.id_rs);
        ex_rt  = prod(idex_valid, idex_rw, idex_dst, hif.id_rt);
        mem_rs = prod(exmem_valid, exmem_rw, exmem_dst, hif.id_rs);
        mem_rt = prod(exmem_valid, exmem_rw, exmem_dst, hif.id_rt);
        lu = hif.id_valid & idex_mr &
             ((hif.id_uses_rs & ex_rs) |
              (hif.id_uses_rt & ~hif.id_alu_src & ex_rt));
        sd = hif.id_valid & hif.id_alu_src & hif.id_uses_rt & (ex_rt | mem_rt);
        hz = lu | sd;
        fwd1 = 2'b00;
        if (hif.id_uses_rs & ex_rs)
            fwd1 = 2'b10;
        else if (hif.id_uses_rs & mem_rs)
            fwd1 = 2'b01;
        fwd2 = 2'b00;
        if (hif.id_uses_rt & ~hif.id_alu_src & ex_rt)
            fwd2 = 2'b10;
        else if (hif.id_uses_rt & ~hif.id_alu_src & mem_rt)
            fwd2 = 2'b01;
    end

    // Pipeline register controls; reset beats freeze, branch beats hazard.
    always_comb begin
        hif.pc_write    = 1'b0;
        hif.ifid_write  = 1'b0;
        hif.ifid_flush  = 1'b0;
        bubble          = 1'b0;
        if (!rst_n) begin
            bubble = 1'b1;
        end else if (hif.ext_stall) begin
            bubble = 1'b0;
        end else if (hif.ex_branch_taken) begin
            hif.pc_write   = 1'b1;
            hif.ifid_write = 1'b1;
            hif.ifid_flush = 1'b1;
            bubble         = 1'b1;
        end else if (hz) begin
            bubble = 1'b1;
        end else begin
            hif.pc_write   = 1'b1;
            hif.ifid_write = 1'b1;
        end
        hif.idex_bubble = bubble;
        hif.stalled     = rst_n & (state == STALL);
    end

    // Tracking, FSM, forwarding selects and statistics advance together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= RUN;
            idex_valid      <= 1'b0;
            idex_rw         <= 1'b0;
            idex_mr         <= 1'b0;
            idex_dst        <= '0;
            exmem_valid     <= 1'b0;
            exmem_rw        <= 1'b0;
            exmem_dst       <= '0;
            hif.c_data1_src <= 2'b00;
            hif.c_data2_src <= 2'b00;
`ifdef HAZARD_STATS_EN
            stall_cnt       <= '0;
            flush_cnt       <= '0;
`endif
        end else if (!hif.ext_stall) begin
            exmem_valid <= idex_valid;
            exmem_rw    <= idex_rw;
            exmem_dst   <= idex_dst;
            if (bubble) begin
                idex_valid      <= 1'b0;
                idex_rw         <= 1'b0;
                idex_mr         <= 1'b0;
                idex_dst        <= '0;
                hif.c_data1_src <= 2'b00;
                hif.c_data2_src <= 2'b00;
            end else begin
                idex_valid      <= hif.id_valid;
                idex_rw         <= hif.id_reg_write;
                idex_mr         <= hif.id_mem_read;
                idex_dst        <= hif.id_dst;
                hif.c_data1_src <= fwd1;
                hif.c_data2_src <= fwd2;
            end
            if (hif.ex_branch_taken)
                state <= RUN;
            else
                state <= hz ? STALL : RUN;
`ifdef HAZARD_STATS_EN
            if (hz & ~hif.ex_branch_taken)
                stall_cnt <= stall_cnt + 32'd1;
            if (hif.ex_branch_taken)
                flush_cnt <= flush_cnt + 32'd1;
`endif
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios then
// randomized traffic, all checked against an in-flight instruction model.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) hif ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
    hazard_ctrl #(.REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .hif(hif),
                                   .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    hazard_ctrl #(.REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .hif(hif));
`endif

    // Model: the two in-flight instructions ahead of ID.
    typedef struct packed {
        logic       v;
        logic       rw;
        logic       mr;
        logic [4:0] dst;
    } slot_t;

    slot_t       m_ex, m_mem;
    logic [1:0]  m_sel1, m_sel2;
    logic        m_st;
    logic [31:0] m_scnt, m_fcnt;

    function automatic bit writes(slot_t s, logic [4:0] r);
        return s.v && s.rw && s.dst != 5'd0 && s.dst == r;
    endfunction

    function automatic logic [1:0] src_for(bit used, logic [4:0] r);
        if (!used) return 2'b00;
        if (writes(m_ex, r)) return 2'b10;
        if (writes(m_mem, r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit hazard();
        bit lu, sd;
        lu = hif.id_valid && m_ex.v && m_ex.mr &&
             ((hif.id_uses_rs && writes(m_ex, hif.id_rs)) ||
              (hif.id_uses_rt && !hif.id_alu_src && writes(m_ex, hif.id_rt)));
        sd = hif.id_valid && hif.id_alu_src && hif.id_uses_rt &&
             (writes(m_ex, hif.id_rt) || writes(m_mem, hif.id_rt));
        return lu || sd;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(bit v, int rs, int rt, bit urs, bit urt, bit alu,
                          int dst, bit rw, bit mr);
        hif.id_valid     = v;
        hif.id_rs        = 5'(rs);
        hif.id_rt        = 5'(rt);
        hif.id_uses_rs   = urs;
        hif.id_uses_rt   = urt;
        hif.id_alu_src   = alu;
        hif.id_dst       = 5'(dst);
        hif.id_reg_write = rw;
        hif.id_mem_read  = mr;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check every output mid-cycle, then advance the model.
    task automatic cycle();
        bit hz, br;
        logic [3:0] e;  // pc_write, ifid_write, ifid_flush, idex_bubble
        @(negedge clk);
        hz = hazard();
        br = hif.ex_branch_taken;
        if (!rst_n)              e = 4'b0001;
        else if (hif.ext_stall)  e = 4'b0000;
        else if (br)             e = 4'b1111;
        else if (hz)             e = 4'b0001;
        else                     e = 4'b1100;
        chk("pc_write",    32'(hif.pc_write),    32'(e[3]));
        chk("ifid_write",  32'(hif.ifid_write),  32'(e[2]));
        chk("ifid_flush",  32'(hif.ifid_flush),  32'(e[1]));
        chk("idex_bubble", 32'(hif.idex_bubble), 32'(e[0]));
        chk("stalled",     32'(hif.stalled),     32'(rst_n & m_st));
        chk("c_data1_src", 32'(hif.c_data1_src), 32'(m_sel1));
        chk("c_data2_src", 32'(hif.c_data2_src), 32'(m_sel2));
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, m_scnt);
        chk("flush_cnt", flush_cnt, m_fcnt);
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_sel1 = 2'b00; m_sel2 = 2'b00;
            m_st = 1'b0; m_scnt = 0; m_fcnt = 0;
        end else if (!hif.ext_stall) begin
            if (br || hz) begin
                m_sel1 = 2'b00;
                m_sel2 = 2'b00;
            end else begin
                m_sel1 = src_for(hif.id_uses_rs, hif.id_rs);
                m_sel2 = src_for(hif.id_uses_rt && !hif.id_alu_src, hif.id_rt);
            end
            m_mem = m_ex;
            m_ex  = (br || hz) ? slot_t'(0)
                    : slot_t'{hif.id_valid, hif.id_reg_write, hif.id_mem_read, hif.id_dst};
            m_st  = hz && !br;
            if (hz && !br) m_scnt++;
            if (br) m_fcnt++;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        hif.ext_stall = 1'b0;
        hif.ex_branch_taken = 1'b0;
        nop();
        m_ex = '0; m_mem = '0; m_sel1 = 2'b00; m_sel2 = 2'b00;
        m_st = 1'b0; m_scnt = 0; m_fcnt = 0;
        @(posedge clk); #1;
        cycle();                       // reset state checked by model
        rst_n = 1'b1;

        // Load-use: lw $2,0($1) ; add $4,$2,$6
        set_id(1, 1, 0, 1, 0, 1, 2, 1, 1); cycle();
        set_id(1, 2, 6, 1, 1, 0, 4, 1, 0); #1;
        chk("lu_pc_write", 32'(hif.pc_write), 0);
        chk("lu_bubble",   32'(hif.idex_bubble), 1);
        cycle();
        chk("lu_stalled",  32'(hif.stalled), 1);
        chk("lu_release",  32'(hif.pc_write), 1);
        cycle();
        chk("lu_fwd_wb",   32'(hif.c_data1_src), 32'(2'b01));
        nop(); cycle(); cycle();

        // Branch beats load-use
        set_id(1, 1, 0, 1, 0, 1, 2, 1, 1); cycle();
        set_id(1, 2, 6, 1, 1, 0, 4, 1, 0);
        hif.ex_branch_taken = 1'b1; #1;
        chk("br_flush", 32'(hif.ifid_flush), 1);
        chk("br_pc",    32'(hif.pc_write), 1);
        cycle();
        hif.ex_branch_taken = 1'b0; nop(); #1;
        chk("br_no_stall", 32'(hif.stalled), 0);
        cycle(); cycle();
`ifdef HAZARD_STATS_EN
        chk("stats_stall", stall_cnt, 1);
        chk("stats_flush", flush_cnt, 1);
`endif

        // Back-to-back: add $3,$1,$2 ; sub $4,$3,$5
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0); cycle();
        set_id(1, 3, 5, 1, 1, 0, 4, 1, 0); cycle();
        chk("b2b_exmem", 32'(hif.c_data1_src), 32'(2'b10));
        // One independent instruction in between
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0); cycle();
        set_id(1, 1, 2, 1, 1, 0, 9, 1, 0); cycle();
        set_id(1, 3, 5, 1, 1, 0, 4, 1, 0); #1;
        chk("gap_no_stall", 32'(hif.pc_write), 1);
        cycle();
        chk("gap_memwb", 32'(hif.c_data1_src), 32'(2'b01));
        nop(); cycle(); cycle();

        // Store-data: add $7 ; sw $7,4($1) -> two stall cycles
        set_id(1, 1, 2, 1, 1, 0, 7, 1, 0); cycle();
        set_id(1, 1, 7, 1, 1, 1, 0, 0, 0); #1;
        chk("sd_stall1", 32'(hif.pc_write), 0);
        cycle(); chk("sd_stall2", 32'(hif.pc_write), 0);
        cycle(); chk("sd_go", 32'(hif.pc_write), 1);
        cycle(); chk("sd_sel2", 32'(hif.c_data2_src), 0);
        // $0 destination never stalls
        set_id(1, 1, 2, 1, 1, 0, 0, 1, 0); cycle();
        set_id(1, 1, 0, 1, 1, 1, 0, 0, 0); #1;
        chk("sd_r0", 32'(hif.pc_write), 1);
        cycle(); nop(); cycle(); cycle();

        // Freeze for three cycles mid-dependency
        set_id(1, 1, 2, 1, 1, 0, 3, 1, 0); cycle();
        set_id(1, 3, 5, 1, 1, 0, 4, 1, 0);
        hif.ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        hif.ext_stall = 1'b0; cycle();
        chk("frz_fwd", 32'(hif.c_data1_src), 32'(2'b10));
        nop(); cycle();

        // Reset during a store-data stall
        set_id(1, 1, 2, 1, 1, 0, 7, 1, 0); cycle();
        set_id(1, 1, 7, 1, 1, 1, 0, 0, 0); cycle();
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; nop(); #1;
        chk("rst_stalled", 32'(hif.stalled), 0);
        chk("rst_sel1", 32'(hif.c_data1_src), 0);
        cycle();

        // Randomized traffic over a small register window
        for (int n = 0; n < 600; n++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0);
            hif.ex_branch_taken = ($urandom_range(0, 7) == 0);
            hif.ext_stall       = ($urandom_range(0, 7) == 0);
            rst_n               = ($urandom_range(0, 63) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
